// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Round-robin arbitration is selected with the WB_RR_EN macro.
package wb_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_SRC    = 3;
    localparam int FIFO_DEPTH = 2;

    localparam logic REG_INT   = 1'b0;
    localparam logic REG_FLOAT = 1'b1;

    typedef struct packed {
        logic [4:0]      rd;
        logic            reg_type;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry result FIFO with a registered ready flag.
// Entry 0 is always the head; a pop shifts entry 1 down.
module wb_fifo2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  wb_req_t    din,
    output wb_req_t    head,
    output logic [1:0] count,
    output logic       ready
);

    wb_req_t    mem [FIFO_DEPTH];
    logic [1:0] count_nxt;
    logic       wr_idx;

    assign head = mem[0];
    assign wr_idx = pop ? (count == 2'd2) : (count == 2'd1);

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = 2'd0;
        else if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count  <= 2'd0;
            ready  <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            count <= count_nxt;
            ready <= (count_nxt != 2'(FIFO_DEPTH));
            if (!flush) begin
                if (pop)
                    mem[0] <= mem[1];
                // Later assignment wins when push lands in slot 0.
                if (push)
                    mem[wr_idx] <= din;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges per-unit results into the single register file write port.
// Define WB_RR_EN for round-robin arbitration, else fixed priority.
module wb_arbiter #(
    parameter int NUM_SRC = wb_pkg::NUM_SRC,
    parameter int XLEN    = wb_pkg::XLEN
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC-1:0][4:0]       src_rd,
    input  logic [NUM_SRC-1:0]            src_type,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  src_data,
    output logic [4:0]                    rd_wb,
    output logic                          reg_type_wb,
    output logic [XLEN-1:0]               op_wb,
    output logic                          we_rd_wb,
    output logic                          wb_busy
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_pkg::wb_req_t    head [NUM_SRC];
    wb_pkg::wb_req_t    win;
    logic [1:0]         count [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] nonempty;
    logic               found;
    logic [IW-1:0]      sel;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_pkg::wb_req_t req;
        logic            is_x0;

        assign req.rd       = src_rd[i];
        assign req.reg_type = src_type[i];
        assign req.data     = src_data[i];

        // Writes to x0 are handshaken but never reach the FIFO.
        assign is_x0 = (src_type[i] == wb_pkg::REG_INT) &&
                       (src_rd[i] == 5'd0);
        assign push[i] = src_valid[i] && src_ready[i] &&
                         !flush && !is_x0;
        assign pop[i] = found && (sel == IW'(i)) && !flush;
        assign nonempty[i] = (count[i] != 2'd0);

        wb_fifo2 u_fifo (
            .clk     (clk),
            .n_reset (n_reset),
            .flush   (flush),
            .push    (push[i]),
            .pop     (pop[i]),
            .din     (req),
            .head    (head[i]),
            .count   (count[i]),
            .ready   (src_ready[i])
        );
    end

`ifdef WB_RR_EN
    logic [IW-1:0] ptr;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            ptr <= IW'(NUM_SRC - 1);
        else if (found && !flush)
            ptr <= sel;
    end

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        sel   = '0;
        win   = head[0];
        for (int k = 1; k <= NUM_SRC; k++) begin
            j = (int'(ptr) + k) % NUM_SRC;
            if (!found && nonempty[j]) begin
                found = 1'b1;
                sel   = IW'(j);
                win   = head[j];
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        sel   = '0;
        win   = head[0];
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (nonempty[k]) begin
                found = 1'b1;
                sel   = IW'(k);
                win   = head[k];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            we_rd_wb    <= 1'b0;
            rd_wb       <= 5'd0;
            reg_type_wb <= 1'b0;
            op_wb       <= '0;
        end else if (flush) begin
            we_rd_wb <= 1'b0;
        end else if (found) begin
            we_rd_wb    <= 1'b1;
            rd_wb       <= win.rd;
            reg_type_wb <= win.reg_type;
            op_wb       <= win.data;
        end else begin
            we_rd_wb <= 1'b0;
        end
    end

    assign wb_busy = (|nonempty) || we_rd_wb;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based model.
// Build with WB_RR_EN defined to check round-robin arbitration.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 64;

    logic                  clk = 1'b0;
    logic                  n_reset = 1'b0;
    logic                  flush = 1'b0;
    logic [N-1:0]          src_valid;
    logic [N-1:0]          src_ready;
    logic [N-1:0][4:0]     src_rd;
    logic [N-1:0]          src_type;
    logic [N-1:0][XL-1:0]  src_data;
    logic [4:0]            rd_wb;
    logic                  reg_type_wb;
    logic [XL-1:0]         op_wb;
    logic                  we_rd_wb;
    logic                  wb_busy;

    typedef struct {
        logic [4:0]  rd;
        logic        t;
        logic [63:0] d;
    } req_t;

    req_t pend [N][$];
    req_t mq   [N][$];

    logic [N-1:0] m_rdy;
    logic         m_we;
    logic [4:0]   m_rd;
    logic         m_t;
    logic [63:0]  m_d;
    int           m_ptr;

    int checks = 0;
    int errors = 0;
    int obs_writes = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_rd      (src_rd),
        .src_type    (src_type),
        .src_data    (src_data),
        .rd_wb       (rd_wb),
        .reg_type_wb (reg_type_wb),
        .op_wb       (op_wb),
        .we_rd_wb    (we_rd_wb),
        .wb_busy     (wb_busy)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int j;
        for (int k = 1; k <= N; k++) begin
`ifdef WB_RR_EN
            j = (m_ptr + k) % N;
`else
            j = k - 1;
`endif
            if (mq[j].size() > 0)
                return j;
        end
        return -1;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = m_we;
        for (int i = 0; i < N; i++)
            if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic pend_any();
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++)
            if (pend[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            pend[i].delete();
        end
        m_rdy = '0;
        m_we  = 1'b0;
        m_rd  = 5'd0;
        m_t   = 1'b0;
        m_d   = 64'd0;
        m_ptr = N - 1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0) begin
                src_valid[i] = 1'b1;
                src_rd[i]    = pend[i][0].rd;
                src_type[i]  = pend[i][0].t;
                src_data[i]  = pend[i][0].d;
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] xfer;
        req_t         r;
        int           w;
        xfer = src_valid & m_rdy;
        if (flush) begin
            m_we = 1'b0;
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rdy = '1;
        end else begin
            w = pick();
            m_we = (w >= 0);
            if (w >= 0) begin
                r = mq[w].pop_front();
                m_rd  = r.rd;
                m_t   = r.t;
                m_d   = r.d;
                m_ptr = w;
            end
            for (int i = 0; i < N; i++) begin
                if (xfer[i] && !(src_type[i] == 1'b0 && src_rd[i] == 5'd0)) begin
                    r.rd = src_rd[i];
                    r.t  = src_type[i];
                    r.d  = src_data[i];
                    mq[i].push_back(r);
                end
            end
            for (int i = 0; i < N; i++)
                m_rdy[i] = (mq[i].size() < 2);
        end
        for (int i = 0; i < N; i++)
            if (xfer[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("we_rd_wb", we_rd_wb, m_we);
        chk("rd_wb", rd_wb, m_rd);
        chk("reg_type_wb", reg_type_wb, m_t);
        chk("op_wb", op_wb, m_d);
        chk("src_ready", src_ready, m_rdy);
        chk("wb_busy", wb_busy, model_busy());
        if (we_rd_wb === 1'b1) obs_writes++;
        @(negedge clk);
        drive();
    endtask

    task automatic drain(int maxc);
        int c;
        c = 0;
        while ((pend_any() || model_busy()) && c < maxc) begin
            step();
            c++;
        end
        chk("drain_bound", (c < maxc), 1);
        step();
    endtask

    task automatic add(int s, logic [4:0] rd, logic t, logic [63:0] d);
        req_t r;
        r.rd = rd;
        r.t  = t;
        r.d  = d;
        pend[s].push_back(r);
    endtask

    task automatic reset_check(string tag);
        chk({tag, "_we"}, we_rd_wb, 0);
        chk({tag, "_rd"}, rd_wb, 0);
        chk({tag, "_type"}, reg_type_wb, 0);
        chk({tag, "_op"}, op_wb, 0);
        chk({tag, "_ready"}, src_ready, 0);
        chk({tag, "_busy"}, wb_busy, 0);
    endtask

    initial begin
        src_valid = '0;
        src_rd    = '0;
        src_type  = '0;
        src_data  = '0;
        model_reset();

        #3;
        reset_check("rst");
        @(negedge clk);
        n_reset = 1'b1;
        step();
        chk("ready_after_rst", src_ready, 3'b111);

        // single integer write, one cycle after the transfer
        add(0, 5'd5, 1'b0, 64'h1234);
        drive();
        step();
        step();
        chk("single_we", we_rd_wb, 1);
        chk("single_rd", rd_wb, 5);
        chk("single_op", op_wb, 64'h1234);
        step();
        chk("single_pulse", we_rd_wb, 0);

        // x0 is dropped, f0 is written
        obs_writes = 0;
        add(0, 5'd0, 1'b0, 64'h55);
        add(0, 5'd0, 1'b1, 64'hAB);
        drive();
        drain(20);
        chk("x0_writes", obs_writes, 1);
        chk("f0_type", reg_type_wb, 1);
        chk("f0_op", op_wb, 64'hAB);

        // three sources streaming three results each
        obs_writes = 0;
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 3; k++)
                add(s, 5'(1 + s * 3 + k), 1'(s == 2), 64'(s * 16 + k));
        drive();
        drain(40);
        chk("stream_writes", obs_writes, 9);

        // src1 backs up while src0 streams
        for (int k = 0; k < 3; k++) add(1, 5'(10 + k), 1'b0, 64'(100 + k));
        for (int k = 0; k < 5; k++) add(0, 5'(20 + k), 1'b0, 64'(200 + k));
        drive();
        drain(40);

        // flush with every FIFO loaded
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 3; k++)
                add(s, 5'(7 + k), 1'b1, 64'(300 + s * 4 + k));
        drive();
        step();
        step();
        flush = 1'b1;
        for (int s = 0; s < N; s++) pend[s].delete();
        step();
        flush = 1'b0;
        drive();
        chk("flush_busy", wb_busy, 0);
        chk("flush_we", we_rd_wb, 0);
        obs_writes = 0;
        for (int k = 0; k < 4; k++) step();
        chk("flush_nowrite", obs_writes, 0);

        // asynchronous reset with FIFOs loaded
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 3; k++)
                add(s, 5'(3 + k), 1'b0, 64'(400 + s * 4 + k));
        drive();
        step();
        step();
        #2;
        n_reset = 1'b0;
        #1;
        reset_check("async_rst");
        model_reset();
        drive();
        @(negedge clk);
        n_reset = 1'b1;
        obs_writes = 0;
        for (int k = 0; k < 5; k++) step();
        chk("rst_nowrite", obs_writes, 0);

        // random traffic with occasional flush
        for (int c = 0; c < 500; c++) begin
            for (int s = 0; s < N; s++) begin
                if (pend[s].size() < 2 && $urandom_range(2) == 0)
                    add(s, ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
                        1'($urandom), {$urandom, $urandom});
            end
            flush = ($urandom_range(39) == 0);
            drive();
            step();
        end
        flush = 1'b0;
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
